icb_lite_reg_bank: RTL and testbench

- Parametrised ICB-lite slave register bank for the SoC peripheral bus.
- Provides REG_NUM 32-bit software-writable control registers at a configurable base address, with read-back, a registered response channel, decode error reporting and a one-cycle write strobe per register.
- Lets the CPU hand lengths, modes and DDR addresses to accelerator blocks.

---
 rtl/icb_lite_reg_bank.sv | 126 ++++++++++++
 tb/tb_icb_lite_reg_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_lite_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icb_lite_reg_bank
// Description : ICB-lite slave bank of REG_NUM 32-bit control registers with
//               read-back, one-deep registered response and write strobes.
//               Define ICB_REG_WMASK_EN for byte-masked writes.
// Revision    : 1.0 - initial release
// ============================================================================
module icb_lite_reg_bank #(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          REG_NUM   = 8
) (
    input  logic                   sys_clk_50m,
    input  logic                   hard_rst_n,
    input  logic                   icb_cmd_valid,
    output logic                   icb_cmd_ready,
    input  logic [31:0]            icb_cmd_addr,
    input  logic                   icb_cmd_read,
    input  logic [31:0]            icb_cmd_wdata,
    input  logic [3:0]             icb_cmd_wmask,
    output logic                   icb_rsp_valid,
    input  logic                   icb_rsp_ready,
    output logic [31:0]            icb_rsp_rdata,
    output logic                   icb_rsp_err,
    output logic [32*REG_NUM-1:0]  reg_out,
    output logic [REG_NUM-1:0]     reg_wr_pulse
);

    localparam int          c_IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [31:0] c_SPAN  = 32'(4 * REG_NUM);

    logic [REG_NUM-1:0][31:0] r_regs_q, w_regs_d;
    logic [REG_NUM-1:0]       r_wr_pulse_q, w_wr_pulse_d;
    logic                     r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0]              r_rsp_rdata_q, w_rsp_rdata_d;
    logic                     r_rsp_err_q, w_rsp_err_d;

    logic [31:0]        w_offset;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_index;
    logic               w_cmd_fire;
    logic [31:0]        w_rd_data;

    // Addresses below the base wrap to large offsets and therefore miss.
    assign w_offset   = icb_cmd_addr - BASE_ADDR;
    assign w_hit      = (w_offset < c_SPAN) && (icb_cmd_addr[1:0] == 2'b00);
    assign w_index    = w_offset[c_IDX_W+1:2];
    assign w_cmd_fire = icb_cmd_valid && icb_cmd_ready;

    assign icb_cmd_ready = !r_rsp_valid_q || icb_rsp_ready;

`ifndef ICB_REG_WMASK_EN
    logic w_unused_wmask;
    assign w_unused_wmask = ^icb_cmd_wmask;
`endif

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (w_index == c_IDX_W'(i)) begin
                w_rd_data = r_regs_q[i];
            end
        end
    end

    always_comb begin
        w_regs_d     = r_regs_q;
        w_wr_pulse_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (w_cmd_fire && !icb_cmd_read && w_hit && (w_index == c_IDX_W'(i))) begin
                w_wr_pulse_d[i] = 1'b1;
`ifdef ICB_REG_WMASK_EN
                for (int b = 0; b < 4; b++) begin
                    if (icb_cmd_wmask[b]) begin
                        w_regs_d[i][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                    end
                end
`else
                w_regs_d[i] = icb_cmd_wdata;
`endif
            end
        end
    end

    // A newly accepted command replaces the response in the same cycle the
    // old one is consumed, giving one command per cycle when unstalled.
    always_comb begin
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;
        if (w_cmd_fire) begin
            w_rsp_valid_d = 1'b1;
            w_rsp_err_d   = !w_hit;
            w_rsp_rdata_d = (icb_cmd_read && w_hit) ? w_rd_data : 32'h0;
        end else if (icb_rsp_ready) begin
            w_rsp_valid_d = 1'b0;
            w_rsp_rdata_d = 32'h0;
            w_rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_50m or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            r_regs_q      <= '0;
            r_wr_pulse_q  <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= 32'h0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_regs_q      <= w_regs_d;
            r_wr_pulse_q  <= w_wr_pulse_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    assign reg_out       = r_regs_q;
    assign reg_wr_pulse  = r_wr_pulse_q;
    assign icb_rsp_valid = r_rsp_valid_q;
    assign icb_rsp_rdata = r_rsp_rdata_q;
    assign icb_rsp_err   = r_rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_icb_lite_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_icb_lite_reg_bank
// Description : Directed bench for icb_lite_reg_bank with a response
//               scoreboard; honours ICB_REG_WMASK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icb_lite_reg_bank;

    localparam logic [31:0] c_BASE = 32'hC000_0000;
    localparam int          c_NUM  = 8;

    logic                   sys_clk_50m = 1'b0;
    logic                   hard_rst_n;
    logic                   icb_cmd_valid;
    logic                   icb_cmd_ready;
    logic [31:0]            icb_cmd_addr;
    logic                   icb_cmd_read;
    logic [31:0]            icb_cmd_wdata;
    logic [3:0]             icb_cmd_wmask;
    logic                   icb_rsp_valid;
    logic                   icb_rsp_ready;
    logic [31:0]            icb_rsp_rdata;
    logic                   icb_rsp_err;
    logic [32*c_NUM-1:0]    reg_out;
    logic [c_NUM-1:0]       reg_wr_pulse;

    logic [c_NUM-1:0][31:0] exp_regs;
    logic [32:0]            exp_q[$];
    int                     tests = 0;
    int                     fails = 0;

    always #10 sys_clk_50m = ~sys_clk_50m;

    icb_lite_reg_bank #(
        .BASE_ADDR (c_BASE),
        .REG_NUM   (c_NUM)
    ) u_dut (
        .sys_clk_50m   (sys_clk_50m),
        .hard_rst_n    (hard_rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one command, wait for acceptance, then predict its effects.
    task automatic cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, output int waits);
        logic        rdy;
        logic [31:0] offs;
        logic        hit;
        int          idx;
        logic [c_NUM-1:0] exp_pulse;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        waits = 0;
        do begin
            @(negedge sys_clk_50m);
            rdy = icb_cmd_ready;
            @(posedge sys_clk_50m);
            #1;
            if (!rdy) waits++;
        end while (!rdy && waits <= 100);
        icb_cmd_valid = 1'b0;
        if (!rdy) begin
            check("cmd_accept_timeout", 256'(waits), 256'(0));
            return;
        end
        offs      = addr - c_BASE;
        hit       = (offs < 32'd32) && (addr[1:0] == 2'b00);
        idx       = int'(offs[4:2]);
        exp_pulse = '0;
        if (rd) begin
            exp_q.push_back({!hit, hit ? exp_regs[idx] : 32'h0});
        end else begin
            exp_q.push_back({!hit, 32'h0});
            if (hit) begin
                exp_pulse[idx] = 1'b1;
`ifdef ICB_REG_WMASK_EN
                for (int b = 0; b < 4; b++)
                    if (wm[b]) exp_regs[idx][8*b +: 8] = wd[8*b +: 8];
`else
                exp_regs[idx] = wd;
`endif
            end
        end
        check("wr_pulse", 256'(reg_wr_pulse), 256'(exp_pulse));
        check("reg_out", 256'(reg_out), 256'(exp_regs));
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge sys_clk_50m);
        #1;
        check("drain_pending", 256'(exp_q.size()), 256'(0));
    endtask

    always @(negedge sys_clk_50m) begin
        if (hard_rst_n && icb_rsp_valid && icb_rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 256'(exp_q.size()), 256'(1));
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", 256'(icb_rsp_rdata), 256'(e[31:0]));
                check("rsp_err", 256'(icb_rsp_err), 256'(e[32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        logic [31:0] held;
        exp_regs      = '0;
        hard_rst_n    = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge sys_clk_50m);
        #1;
        check("rst_rsp_valid", 256'(icb_rsp_valid), 256'(0));
        check("rst_rsp_rdata", 256'(icb_rsp_rdata), 256'(0));
        check("rst_rsp_err", 256'(icb_rsp_err), 256'(0));
        check("rst_reg_out", 256'(reg_out), 256'(0));
        check("rst_pulse", 256'(reg_wr_pulse), 256'(0));
        @(negedge sys_clk_50m);
        hard_rst_n = 1'b1;
        @(posedge sys_clk_50m);
        #1;
        check("rst_cmd_ready", 256'(icb_cmd_ready), 256'(1));

        // Read every register after reset
        for (int i = 0; i < c_NUM; i++) cmd(1'b1, c_BASE + 32'(4*i), 32'h0, 4'h0, w);
        drain();

        // Full write and read-back
        cmd(1'b0, 32'hC000_0008, 32'hDEAD_BEEF, 4'hF, w);
        check("reg2_slice", 256'(reg_out[95:64]), 256'(32'hDEAD_BEEF));
        cmd(1'b1, 32'hC000_0008, 32'h0, 4'h0, w);

        // Partial-mask write, then a zero-mask write that still pulses
        cmd(1'b0, 32'hC000_0008, 32'h1122_3344, 4'b0101, w);
        cmd(1'b1, 32'hC000_0008, 32'h0, 4'h0, w);
        cmd(1'b0, 32'hC000_0008, 32'hFFFF_FFFF, 4'b0000, w);
        cmd(1'b1, 32'hC000_0008, 32'h0, 4'h0, w);

        // Decode misses
        cmd(1'b0, 32'hC000_0020, 32'hFFFF_FFFF, 4'hF, w);
        cmd(1'b1, 32'hC000_0020, 32'h0, 4'h0, w);
        cmd(1'b1, 32'hC000_0002, 32'h0, 4'h0, w);
        cmd(1'b0, 32'hC000_0002, 32'h1234_5678, 4'hF, w);
        cmd(1'b0, 32'hBFFF_FFFC, 32'hFFFF_FFFF, 4'hF, w);

        // Read then write the same register back to back
        cmd(1'b0, 32'hC000_000C, 32'h0000_00AA, 4'hF, w);
        cmd(1'b1, 32'hC000_000C, 32'h0, 4'h0, w);
        cmd(1'b0, 32'hC000_000C, 32'h0000_00BB, 4'hF, w);
        cmd(1'b0, 32'hC000_000C, 32'h0000_00CC, 4'hF, w);
        cmd(1'b1, 32'hC000_000C, 32'h0, 4'h0, w);
        drain();

        // Back-pressure: response must hold and cmd_ready must drop
        icb_rsp_ready = 1'b0;
        held = exp_regs[2];
        cmd(1'b1, 32'hC000_0008, 32'h0, 4'h0, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk_50m);
            check("bp_rsp_valid", 256'(icb_rsp_valid), 256'(1));
            check("bp_rsp_rdata", 256'(icb_rsp_rdata), 256'(held));
            check("bp_cmd_ready", 256'(icb_cmd_ready), 256'(0));
        end
        @(posedge sys_clk_50m);
        #1;
        icb_rsp_ready = 1'b1;

        // Sixteen back-to-back writes at full rate
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            cmd(1'b0, c_BASE + 32'(4*(i%8)), 32'h5000_0000 + 32'(i), 4'hF, w);
            if (i > 0) wsum += w;
        end
        check("stream_stalls", 256'(wsum), 256'(0));
        for (int i = 0; i < c_NUM; i++) cmd(1'b1, c_BASE + 32'(4*i), 32'h0, 4'h0, w);
        drain();

        // Asynchronous reset with a pending response and nonzero registers
        icb_rsp_ready = 1'b0;
        cmd(1'b0, 32'hC000_0014, 32'hA5A5_0001, 4'hF, w);
        check("pre_rst_rsp_valid", 256'(icb_rsp_valid), 256'(1));
        #3;
        hard_rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 256'(icb_rsp_valid), 256'(0));
        check("arst_reg_out", 256'(reg_out), 256'(0));
        check("arst_pulse", 256'(reg_wr_pulse), 256'(0));
        check("arst_rsp_err", 256'(icb_rsp_err), 256'(0));
        exp_q.delete();
        exp_regs = '0;
        repeat (2) @(posedge sys_clk_50m);
        @(negedge sys_clk_50m);
        hard_rst_n    = 1'b1;
        icb_rsp_ready = 1'b1;
        @(posedge sys_clk_50m);
        #1;
        check("post_rst_cmd_ready", 256'(icb_cmd_ready), 256'(1));
        cmd(1'b1, 32'hC000_0014, 32'h0, 4'h0, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
